// File: rtl/param_stack.sv
// param_stack: parametrised LIFO operand stack for the RPN evaluator.
//
// Each qualified operation pops 0..3 entries and optionally pushes one value,
// all in a single cycle. The top two entries are read combinationally.
//
// Optional feature macro: PARAM_STACK_HIGH_WATER_EN
//   When defined, adds the high_water output: the maximum occupancy reached
//   since reset or since the last clear.
//
// Ports:
//   clk           in   clock, rising-edge
//   rst_n         in   asynchronous active-low reset
//   clear         in   synchronous empty request, overrides any op
//   op_valid      in   qualifies wen/pop_cnt/din
//   wen           in   push din after the pops
//   pop_cnt       in   entries to pop before the push (0..3)
//   din           in   value to push
//   err_clr       in   clears sticky error flags
//   first         out  top of stack, 0 when empty
//   second        out  entry below top, 0 when count<2
//   count         out  occupancy 0..DEPTH
//   empty/full    out  occupancy status
//   op_ack        out  registered pulse: previous op applied
//   op_rej        out  registered pulse: previous op rejected
//   err_underflow out  sticky underflow flag
//   err_overflow  out  sticky overflow flag
//   high_water    out  (macro only) peak occupancy

module param_stack #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  op_valid,
  input  logic                  wen,
  input  logic [1:0]            pop_cnt,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] first,
  output logic [DATA_WIDTH-1:0] second,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  op_ack,
  output logic                  op_rej,
  output logic                  err_underflow,
  output logic                  err_overflow
`ifdef PARAM_STACK_HIGH_WATER_EN
  ,
  output logic [ADDR_WIDTH:0]   high_water
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic          rej_q, rej_d;
  logic          uf_q, uf_d;
  logic          of_q, of_d;

  logic [CW-1:0]         pop_ext;
  logic [CW-1:0]         base;
  logic                  is_under;
  logic                  is_over;
  logic                  apply;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd1_addr;
  logic [ADDR_WIDTH-1:0] rd2_addr;

  // Decode of the requested operation against current occupancy.
  always_comb begin
    pop_ext  = CW'(pop_cnt);
    base     = count_q - pop_ext;
    is_under = pop_ext > count_q;
    // Only reachable with pop_cnt==0 at full, since underflow is checked first.
    is_over  = wen && (base == FULL_CNT);
    apply    = op_valid && !clear;
    accept   = apply && !is_under && !is_over;
    wr_addr  = base[ADDR_WIDTH-1:0];
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (accept) begin
      count_d = base + CW'(wen);
    end

    ack_d = accept;
    rej_d = apply && (is_under || is_over);

    // A fresh error in the same cycle as err_clr still sets its flag.
    uf_d = (err_clr ? 1'b0 : uf_q) | (apply && is_under);
    of_d = (err_clr ? 1'b0 : of_q) | (apply && !is_under && is_over);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  // Storage is deliberately not reset; count alone defines valid entries.
  always_ff @(posedge clk) begin
    if (accept && wen) begin
      mem[wr_addr] <= din;
    end
  end

  // Modulo-DEPTH arithmetic on the low bits gives the right index at full too.
  always_comb begin
    rd1_addr = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    rd2_addr = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(2);
    first    = (count_q >= CW'(1)) ? mem[rd1_addr] : '0;
    second   = (count_q >= CW'(2)) ? mem[rd2_addr] : '0;
  end

  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);
  assign op_ack        = ack_q;
  assign op_rej        = rej_q;
  assign err_underflow = uf_q;
  assign err_overflow  = of_q;

`ifdef PARAM_STACK_HIGH_WATER_EN
  logic [CW-1:0] hw_q, hw_d;

  always_comb begin
    if (clear) begin
      hw_d = '0;
    end else if (count_d > hw_q) begin
      hw_d = count_d;
    end else begin
      hw_d = hw_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q <= '0;
    end else begin
      hw_q <= hw_d;
    end
  end

  assign high_water = hw_q;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Directed, table-driven bench for param_stack with DEPTH=4 (ADDR_WIDTH=2).
module tb_param_stack;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          op_valid;
  logic          wen;
  logic [1:0]    pop_cnt;
  logic [DW-1:0] din;
  logic          err_clr;
  logic [DW-1:0] first;
  logic [DW-1:0] second;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          op_ack;
  logic          op_rej;
  logic          err_underflow;
  logic          err_overflow;
`ifdef PARAM_STACK_HIGH_WATER_EN
  logic [AW:0]   high_water;
`endif

  param_stack #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .op_valid     (op_valid),
    .wen          (wen),
    .pop_cnt      (pop_cnt),
    .din          (din),
    .err_clr      (err_clr),
    .first        (first),
    .second       (second),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .op_ack       (op_ack),
    .op_rej       (op_rej),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow)
`ifdef PARAM_STACK_HIGH_WATER_EN
    ,
    .high_water   (high_water)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        clear;
    logic        op_valid;
    logic        wen;
    logic [1:0]  pop_cnt;
    logic [15:0] din;
    logic        err_clr;
    logic [2:0]  e_count;
    logic [15:0] e_first;
    logic [15:0] e_second;
    logic        e_ack;
    logic        e_rej;
    logic        e_uf;
    logic        e_of;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic cl, logic v, logic w, logic [1:0] p,
                              logic [15:0] d, logic ec, logic [2:0] c, logic [15:0] f,
                              logic [15:0] s, logic a, logic r, logic uf, logic of);
    vec_t t;
    t.name = name; t.clear = cl; t.op_valid = v; t.wen = w; t.pop_cnt = p; t.din = d;
    t.err_clr = ec; t.e_count = c; t.e_first = f; t.e_second = s; t.e_ack = a;
    t.e_rej = r; t.e_uf = uf; t.e_of = of;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clear = 1'b0; op_valid = 1'b0; wen = 1'b0; pop_cnt = 2'd0; din = '0; err_clr = 1'b0;
  endtask

  task automatic check_state(string tag, logic [2:0] c, logic [15:0] f, logic [15:0] s,
                             logic a, logic r, logic uf, logic of);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".first"}, 32'(first), 32'(f));
    chk({tag, ".second"}, 32'(second), 32'(s));
    chk({tag, ".op_ack"}, 32'(op_ack), 32'(a));
    chk({tag, ".op_rej"}, 32'(op_rej), 32'(r));
    chk({tag, ".err_underflow"}, 32'(err_underflow), 32'(uf));
    chk({tag, ".err_overflow"}, 32'(err_overflow), 32'(of));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 3'd0));
    chk({tag, ".full"}, 32'(full), 32'(c == 3'd4));
  endtask

  task automatic apply_vec(vec_t t);
    clear = t.clear; op_valid = t.op_valid; wen = t.wen; pop_cnt = t.pop_cnt;
    din = t.din; err_clr = t.err_clr;
    @(posedge clk);
    #1;
    idle_inputs();
    check_state(t.name, t.e_count, t.e_first, t.e_second, t.e_ack, t.e_rej, t.e_uf, t.e_of);
  endtask

  task automatic push(logic [15:0] d);
    op_valid = 1'b1; wen = 1'b1; pop_cnt = 2'd0; din = d;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    //           name      cl v  w  pop   din    ec cnt first    second   a  r  uf of
    vecs.push_back(mk("push3",   0, 1, 1, 2'd0, 16'h0003, 0, 1, 16'h0003, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk("push4",   0, 1, 1, 2'd0, 16'h0004, 0, 2, 16'h0004, 16'h0003, 1, 0, 0, 0));
    vecs.push_back(mk("add",     0, 1, 1, 2'd2, 16'h0007, 0, 1, 16'h0007, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk("novalid", 0, 0, 1, 2'd1, 16'h00ff, 0, 1, 16'h0007, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("pop1",    0, 1, 0, 2'd1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk("under",   0, 1, 0, 2'd1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0));
    vecs.push_back(mk("nop",     0, 1, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0));
    vecs.push_back(mk("errclr",  0, 0, 0, 2'd0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("p11",     0, 1, 1, 2'd0, 16'h0011, 0, 1, 16'h0011, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk("p22",     0, 1, 1, 2'd0, 16'h0022, 0, 2, 16'h0022, 16'h0011, 1, 0, 0, 0));
    vecs.push_back(mk("p33",     0, 1, 1, 2'd0, 16'h0033, 0, 3, 16'h0033, 16'h0022, 1, 0, 0, 0));
    vecs.push_back(mk("p44",     0, 1, 1, 2'd0, 16'h0044, 0, 4, 16'h0044, 16'h0033, 1, 0, 0, 0));
    vecs.push_back(mk("over",    0, 1, 1, 2'd0, 16'h0055, 0, 4, 16'h0044, 16'h0033, 0, 1, 0, 1));
    vecs.push_back(mk("pop1push",0, 1, 1, 2'd1, 16'h0066, 0, 4, 16'h0066, 16'h0033, 1, 0, 0, 1));
    vecs.push_back(mk("pop2push",0, 1, 1, 2'd2, 16'h0077, 0, 3, 16'h0077, 16'h0022, 1, 0, 0, 1));
    vecs.push_back(mk("p88",     0, 1, 1, 2'd0, 16'h0088, 0, 4, 16'h0088, 16'h0077, 1, 0, 0, 1));
    vecs.push_back(mk("overclr", 0, 1, 1, 2'd0, 16'h0099, 1, 4, 16'h0088, 16'h0077, 0, 1, 0, 1));
    vecs.push_back(mk("ofclr",   0, 0, 0, 2'd0, 16'h0000, 1, 4, 16'h0088, 16'h0077, 0, 0, 0, 0));
    vecs.push_back(mk("pop3",    0, 1, 0, 2'd3, 16'h0000, 0, 1, 16'h0011, 16'h0000, 1, 0, 0, 0));
    vecs.push_back(mk("underw",  0, 1, 1, 2'd2, 16'h00ab, 0, 1, 16'h0011, 16'h0000, 0, 1, 1, 0));
    vecs.push_back(mk("p5a",     0, 1, 1, 2'd0, 16'h005a, 0, 2, 16'h005a, 16'h0011, 1, 0, 1, 0));
    vecs.push_back(mk("clrop",   1, 1, 1, 2'd0, 16'h00aa, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk("clrund",  1, 1, 0, 2'd3, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));

    idle_inputs();
    rst_n = 1'b0;
    #3;
    check_state("reset", 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
`ifdef PARAM_STACK_HIGH_WATER_EN
      if (vecs[i].name == "clrop") begin
        chk("hw.peak", 32'(high_water), 32'd4);
      end
`endif
      apply_vec(vecs[i]);
`ifdef PARAM_STACK_HIGH_WATER_EN
      if (vecs[i].name == "clrop") begin
        chk("hw.clear", 32'(high_water), 32'd0);
      end
`endif
    end

    // Asynchronous reset between edges while an op is pending.
    push(16'h0101);
    push(16'h0202);
    push(16'h0303);
    check_state("pre_rst", 3'd3, 16'h0303, 16'h0202, 1'b1, 1'b0, 1'b1, 1'b0);
    op_valid = 1'b1; wen = 1'b1; din = 16'h0404;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.count", 32'(count), 32'd0);
    chk("async.empty", 32'(empty), 32'd1);
    chk("async.first", 32'(first), 32'd0);
    chk("async.uf", 32'(err_underflow), 32'd0);
    chk("async.ack", 32'(op_ack), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst", 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Push-to-visible latency: first reflects din the cycle after the edge.
    op_valid = 1'b1; wen = 1'b1; din = 16'hbeef;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("lat.first", 32'(first), 32'h0000beef);
    @(posedge clk);
    #1;
    chk("lat.ack_drop", 32'(op_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
